muldiv_sequencer: RTL

- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU, feeding the HI/LO write path of the MIPS32 pipeline.
- Accepts one operation from EX, runs an iterative shift-add multiply or restoring divide, and holds the pipeline via busy_o.
- Presents HI/LO results with a one-cycle done_o pulse for the HI/LO write enables.
- Aborts cleanly on the WB-stage cancel (exception or ERET).

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_iter_step.sv | 35 +++
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the MULT/MULTU/DIV/DIVU sequencer: op encodings,
// FSM states and default widths.
package muldiv_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ITER   = DEFAULT_DATA_W;
  localparam int DEFAULT_CNT_W  = $clog2(DEFAULT_ITER);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Bit 0 of the op code distinguishes unsigned (1) from signed (0).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: a shift-add multiply step or a restoring
// divide step on the {hi,lo} accumulator, selected by is_div.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc_i,
  input  logic [DATA_W-1:0]     operand_i,
  output logic [2*DATA_W-1:0]   acc_o
);

  logic [DATA_W:0] mul_sum;
  logic [DATA_W:0] div_trial;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits; add the
    // multiplicand into the high half when the LSB is set, then shift right
    // keeping the carry.
    mul_sum   = {1'b0, acc_i[2*DATA_W-1:DATA_W]} +
                (acc_i[0] ? {1'b0, operand_i} : {(DATA_W+1){1'b0}});
    // Divide: remainder after the left shift needs DATA_W+1 bits.
    div_trial = acc_i[2*DATA_W-1:DATA_W-1] - {1'b0, operand_i};
    if (is_div) begin
      if (!div_trial[DATA_W])
        acc_o = {div_trial[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b1};
      else
        acc_o = {acc_i[2*DATA_W-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer driving the HI/LO write path.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ITER   = DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t              state_reg;
  logic [1:0]          op_reg;
  logic [DATA_W-1:0]   src_a_reg;
  logic [DATA_W-1:0]   src_b_reg;
  logic [DATA_W-1:0]   opnd_reg;
  logic [2*DATA_W-1:0] acc_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                sign_a_reg;
  logic                sign_b_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   lo_reg;

  logic                is_signed;
  logic                is_div;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [2*DATA_W-1:0] step_acc;
  logic [2*DATA_W-1:0] fix_acc;

  assign is_signed = op_is_signed(op_reg);
  assign is_div    = op_is_div(op_reg);
  assign abs_a     = (is_signed && src_a_reg[DATA_W-1]) ? -src_a_reg : src_a_reg;
  assign abs_b     = (is_signed && src_b_reg[DATA_W-1]) ? -src_b_reg : src_b_reg;

  muldiv_iter_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .is_div    (is_div),
    .acc_i     (acc_reg),
    .operand_i (opnd_reg),
    .acc_o     (step_acc)
  );

  // Sign restoration: quotient takes sign_a^sign_b, remainder follows the dividend.
  always_comb begin
    fix_acc = acc_reg;
    if (is_signed) begin
      if (is_div) begin
        if (sign_a_reg ^ sign_b_reg)
          fix_acc[DATA_W-1:0] = -acc_reg[DATA_W-1:0];
        if (sign_a_reg)
          fix_acc[2*DATA_W-1:DATA_W] = -acc_reg[2*DATA_W-1:DATA_W];
      end else if (sign_a_reg ^ sign_b_reg) begin
        fix_acc = -acc_reg;
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] ext_a;
  logic [2*DATA_W-1:0] ext_b;
  logic [2*DATA_W-1:0] fast_prod;

  // Extending to full width makes one multiplier serve both signednesses.
  always_comb begin
    ext_a     = {{DATA_W{is_signed & src_a_reg[DATA_W-1]}}, src_a_reg};
    ext_b     = {{DATA_W{is_signed & src_b_reg[DATA_W-1]}}, src_b_reg};
    fast_prod = ext_a * ext_b;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      src_a_reg  <= '0;
      src_b_reg  <= '0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else if (state_reg != IDLE && cancel_i) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i && !cancel_i) begin
            op_reg    <= op_i;
            src_a_reg <= src_a_i;
            src_b_reg <= src_b_i;
            busy_reg  <= 1'b1;
            state_reg <= PREP;
          end
        end
        PREP: begin
          sign_a_reg <= is_signed & src_a_reg[DATA_W-1];
          sign_b_reg <= is_signed & src_b_reg[DATA_W-1];
          cnt_reg    <= '0;
          if (is_div && src_b_reg == '0) begin
            acc_reg   <= {src_a_reg, {DATA_W{1'b1}}};
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (is_div) begin
            acc_reg   <= {{DATA_W{1'b0}}, abs_a};
            opnd_reg  <= abs_b;
            state_reg <= CALC;
          end else begin
            acc_reg   <= {{DATA_W{1'b0}}, abs_b};
            opnd_reg  <= abs_a;
            state_reg <= CALC;
          end
        end
        CALC: begin
`ifdef MULDIV_FAST_MUL_EN
          if (!is_div) begin
            acc_reg   <= fast_prod;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else
`endif
          begin
            acc_reg <= step_acc;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST)
              state_reg <= FIX;
          end
        end
        FIX: begin
          acc_reg   <= fix_acc;
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          hi_reg    <= acc_reg[2*DATA_W-1:DATA_W];
          lo_reg    <= acc_reg[DATA_W-1:0];
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Result is presented during the DONE cycle itself; a same-cycle cancel hides it.
  assign busy_o = busy_reg;
  assign done_o = done_reg & ~cancel_i;
  assign hi_o   = done_o ? acc_reg[2*DATA_W-1:DATA_W] : hi_reg;
  assign lo_o   = done_o ? acc_reg[DATA_W-1:0]        : lo_reg;

endmodule
